// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 access-size encodings (LSU_B .. LSU_HU)
//   - FSM state encoding (IDLE, REQ, WAIT, DONE)
//   - size decode helper: funct3 011 and 11x fall through to word
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Map funct3 to an access size; unused encodings behave as word accesses.
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            LSU_B, LSU_BU: sz = SZ_B;
            LSU_H, LSU_HU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
//   Store side: st_funct3/st_off/st_wdata -> st_be, st_wdata_rep, st_misaligned
//   Load side : ld_funct3/ld_off/ld_rdata -> ld_data (aligned, sign/zero extended)
// The store-side alignment check is evaluated for loads as well and drives the
// unit's misaligned flag.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic        st_misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Byte enables, lane replication and alignment check for the incoming access.
    always_comb begin
        st_be         = 4'b0000;
        st_wdata_rep  = 32'h0000_0000;
        st_misaligned = 1'b0;
        case (lsu_size(st_funct3))
            SZ_B: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_be         = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep  = {2{st_wdata[15:0]}};
                st_misaligned = st_off[0];
            end
            SZ_W: begin
                st_be         = 4'b1111;
                st_wdata_rep  = st_wdata;
                st_misaligned = |st_off;
            end
            default: begin
                st_be         = 4'b1111;
                st_wdata_rep  = st_wdata;
                st_misaligned = |st_off;
            end
        endcase
    end

    // Load extraction: move the addressed lane to bit 0, then extend.
    // funct3[2] selects zero extension (BU/HU).
    always_comb begin
        shifted_s = ld_rdata >> {ld_off, 3'b000};
        ld_data   = ld_rdata;
        case (lsu_size(ld_funct3))
            SZ_B: begin
                if (ld_funct3[2]) begin
                    ld_data = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                if (ld_funct3[2]) begin
                    ld_data = {16'h0000, shifted_s[15:0]};
                end else begin
                    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_W:    ld_data = ld_rdata;
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit behind the ALU.
//   Core side : memRead, memWrite, funct3, ALUResult (address), writeData (rs2)
//               -> stall (combinational), readData, loadValid, misaligned, busErr
//   Bus side  : busReq, busWe, busAddr, busWdata, busBe (all registered)
//               <- busReady, busRvalid, busRdata
// A transaction walks IDLE -> REQ -> (WAIT) -> DONE -> IDLE. The optional
// timeout aborts a REQ/WAIT that stalls for TIMEOUT_CYCLES cycles.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit TIMEOUT_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writeData,
    output logic        stall,
    output logic [31:0] readData,
    output logic        loadValid,
    output logic        misaligned,
    output logic        busErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic        busReady,
    input  logic        busRvalid,
    input  logic [31:0] busRdata
);

    // One spare count above the limit so a REQ->WAIT step at the limit cannot wrap.
    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lsu_state_e       state_q, state_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             load_valid_q, load_valid_d;
    logic             misaligned_q, misaligned_d;
    logic             bus_err_q, bus_err_d;
    logic [2:0]       mode_q, mode_d;
    logic [1:0]       off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             valid_s;
    logic             mis_s;
    logic             timeout_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_rep_s;
    logic [31:0]      ld_data_s;

    lsu_align u_align (
        .st_funct3     (funct3),
        .st_off        (ALUResult[1:0]),
        .st_wdata      (writeData),
        .st_be         (be_s),
        .st_wdata_rep  (wdata_rep_s),
        .st_misaligned (mis_s),
        .ld_funct3     (mode_q),
        .ld_off        (off_q),
        .ld_rdata      (busRdata),
        .ld_data       (ld_data_s)
    );

    assign valid_s   = memRead ^ memWrite;
    assign timeout_s = TIMEOUT_EN && (cnt_q >= CNT_MAX);

    // Next-state and output-register logic of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        read_data_d  = read_data_q;
        mode_d       = mode_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                stall = valid_s & ~mis_s;
                if (valid_s && mis_s) begin
                    misaligned_d = 1'b1;
                end else if (valid_s) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = memWrite;
                    bus_addr_d  = {ALUResult[31:2], 2'b00};
                    bus_be_d    = be_s;
                    bus_wdata_d = wdata_rep_s;
                    mode_d      = funct3;
                    off_d       = ALUResult[1:0];
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (busReady) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d = DONE;
                    end else if (busRvalid) begin
                        read_data_d  = ld_data_s;
                        load_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = WAIT;
                    end
                end else if (timeout_s) begin
                    bus_req_d   = 1'b0;
                    read_data_d = 32'h0000_0000;
                    bus_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (busRvalid) begin
                    read_data_d  = ld_data_s;
                    load_valid_d = 1'b1;
                    state_d      = DONE;
                end else if (timeout_s) begin
                    read_data_d = 32'h0000_0000;
                    bus_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0000_0000;
            bus_wdata_q  <= 32'h0000_0000;
            bus_be_q     <= 4'b0000;
            read_data_q  <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            mode_q       <= 3'b000;
            off_q        <= 2'b00;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            read_data_q  <= read_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            mode_q       <= mode_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busReq     = bus_req_q;
    assign busWe      = bus_we_q;
    assign busAddr    = bus_addr_q;
    assign busWdata   = bus_wdata_q;
    assign busBe      = bus_be_q;
    assign readData   = read_data_q;
    assign loadValid  = load_valid_q;
    assign misaligned = misaligned_q;
    assign busErr     = bus_err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit directly downstream of the ALU. It consumes ALUResult as the effective address and rs2 as store data.
- Drives a ready/valid memory bus, and stalls the core while a transaction is outstanding.
- Performs byte-lane steering for stores and alignment plus sign/zero extension for loads.
- Replaces the combinational data memory so the datapath can attach to real SRAM or peripheral buses with variable latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the transaction is aborted with an error.
- TIMEOUT_EN, 1: 1 enables the timeout counter; 0 waits indefinitely.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- memRead  in  1  load instruction in the execute slot.
- memWrite  in  1  store instruction in the execute slot.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  in  32  effective byte address.
- writeData  in  32  store data (rs2).
- stall  out  1  hold PC and pipeline registers.
- readData  out  32  extended load result, registered.
- loadValid  out  1  1-cycle pulse: readData holds new load data.
- misaligned  out  1  1-cycle pulse: access rejected for alignment.
- busErr  out  1  1-cycle pulse: transaction timed out.
- busReq  out  1  bus request, registered.
- busWe  out  1  1 = write.
- busAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- busWdata  out  32  lane-replicated store data.
- busBe  out  4  byte enables.
- busReady  in  1  bus accepts the request this cycle.
- busRvalid  in  1  read data valid.
- busRdata  in  32  read data word.

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge): state=IDLE, busReq=0, busWe=0, busAddr=0, busWdata=0, busBe=0, readData=0, loadValid=0, misaligned=0, busErr=0, timeout counter=0. A reset mid-transaction abandons it; busReq drops at that edge, and any later busRvalid is ignored while in IDLE.
- Access is valid when exactly one of memRead and memWrite is high. Both high is a no-op: no bus access, no stall, no flag.
- Misalignment rules:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - funct3 011/11x is treated as W.
- A misaligned access in IDLE: misaligned pulses next cycle, no stall, no bus traffic.
- stall (combinational) = (IDLE & valid access & ~misaligned) | state==REQ | state==WAIT. In DONE, stall=0 and the core advances.
- IDLE: on a valid, aligned access, latch busAddr, busWe, busBe, busWdata, the size/sign mode and addr[1:0]; set busReq=1; go to REQ.
- REQ: busReq and all bus outputs are held stable until busReady=1.
  - On busReady with a write: busReq=0, go to DONE.
  - On busReady with a read: busReq=0. If busRvalid=1 in the same cycle, capture the data and go to DONE; otherwise go to WAIT.
- WAIT: on busRvalid, capture the extended data into readData and go to DONE.
- DONE: loadValid=1 for loads only. Inputs are ignored. Go to IDLE next cycle.
- Timeout:
  - The counter clears on entering REQ and increments in REQ/WAIT.
  - When TIMEOUT_EN=1 and the count reaches TIMEOUT_CYCLES-1 with no completion: busReq=0, readData=0, busErr pulses in DONE, loadValid=0.
- Store lanes (o = addr[1:0]):
  - SB: busBe=4'b0001<<o, busWdata={4{wd[7:0]}}.
  - SH: busBe = addr[1] ? 4'b1100 : 4'b0011, busWdata={2{wd[15:0]}}.
  - SW: busBe=4'b1111, busWdata=wd.
- Load extract: take busRdata>>(8*o), then use the low byte or halfword, sign-extended (B/H) or zero-extended (BU/HU). W is passed through unchanged.
- Minimum latency: 2 cycles of stall for a load or store with busReady=1 (and busRvalid=1 in the same cycle for a load); the result is available in DONE.
- readData holds its value between loads.

Decomposition:
- Shared package: funct3 size encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and the FSM state encoding (IDLE, REQ, WAIT, DONE).
- One natural sub-module: lsu_align, purely combinational. It generates store byte enables and replicated data, and does load extraction/extension. Its alignment check is reused for the misaligned flag.

Test Plan:
1. SW addr=0x100, wd=0xDEADBEEF, busReady=1 on the first REQ cycle -> busBe=1111, busAddr=0x100, busWe=1, stall high for 2 cycles, no flags.
2. SB addr=0x103, wd=0x000000A5 -> busBe=1000, busWdata=0xA5A5A5A5, busAddr=0x100.
3. LB addr=0x202, busRdata=0x12F0_3456, busRvalid 3 cycles after busReady -> readData=0xFFFFFFF0, loadValid pulse in DONE. The same access as LBU -> 0x000000F0.
4. LH addr=0x301 -> misaligned pulse, busReq never asserted, stall=0. LW addr=0x302 -> same result.
5. LW, busReady never asserted, TIMEOUT_CYCLES=8 -> busReq drops after 8 cycles, busErr pulse, readData=0, loadValid=0, then IDLE.
6. rst_n=0 during WAIT -> next cycle state IDLE, busReq=0, stall=0. A stale busRvalid with busRdata=0x55 afterwards leaves readData=0.
